m_cp0: RTL and testbench
========================

Name: m_cp0

Overview:
Coprocessor-0 for the P7 MIPS pipeline. It is the receiving end of the exception codes raised by the execute stage, including the arithmetic-overflow and address-overflow flags produced by the ALU. It sits at the M stage and owns SR, Cause and EPC. Each cycle it arbitrates hardware interrupts against synchronous exceptions, drives the pipeline flush/redirect request, and serves mfc0/mtc0/eret.

Parameters:
PRID_VALUE, 32'h0000_0707, constant returned on reads of register 15 (PRId).
EXC_ENTRY, 32'h0000_4180, handler address driven on handler_pc.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  mtc0 write enable (M stage)
addr_r  input  5  mfc0 register number
addr_w  input  5  mtc0 register number
wdata  input  32  mtc0 data
rdata  output  32  mfc0 read data, combinational
vpc  input  32  PC of the M-stage instruction (or of the bubble carrying its PC)
bd_in  input  1  M-stage instruction is in a branch delay slot
exc_code_in  input  5  pipelined exception code; 0 = none
hw_int  input  6  external interrupt lines, level-sensitive
eret  input  1  eret in M stage
req  output  1  take exception/interrupt now: flush and redirect
handler_pc  output  32  EXC_ENTRY constant
epc_out  output  32  return address for eret, with forwarding

Behaviour:
- Register layout:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): PRID_VALUE.
  - Any other address reads 0.
- Reset (reset low, asynchronous): SR=0, Cause=0, EPC=0. req is forced 0 while reset is low. rdata/epc_out reflect the cleared registers.
- Cause.IP is loaded from hw_int on every clock edge, regardless of other activity. It is not writable by mtc0.
- Interrupt request: int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL. Uses live hw_int, not latched IP.
- Exception request: exc_req = (exc_code_in != 0) & ~SR.EXL.
- req = int_req | exc_req, combinational, same cycle. Interrupts take priority over exceptions.
- On a clock edge with req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc (32-bit wrap, no alignment check).
  - A concurrent mtc0 or eret is discarded.
- mtc0 (we=1, req=0):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC in full.
  - addr 13, 15 and others are ignored.
- eret (req=0): SR.EXL <= 0 at the edge. If we also targets SR in the same cycle, eret's EXL clear wins over the written EXL bit; the other written bits still apply.
- epc_out = (we & addr_w==14 & ~req) ? wdata : EPC. This forwards an mtc0-then-eret pair without a stall.
- rdata reads the current registers. There is no write-through: mfc0 after mtc0 in the same cycle sees the old value.
- Nested events: while EXL=1, req stays 0 regardless of hw_int or exc_code_in. Exception codes are dropped, not queued.

Optional Feature:
CP0_BADVADDR_EN
- With the macro defined:
  - Adds input badvaddr_in[31:0] and register 8 (BadVAddr), reset to 0.
  - On a req edge with no interrupt and exc_code_in equal to 4 (AdEL) or 5 (AdES), BadVAddr <= badvaddr_in.
  - Read-only to mtc0.
- Without the macro: the port is absent and address 8 reads 0.

Decomposition:
- Shared def package holds:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_BADV=8.
  - ExcCodes: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12.
  - SR/Cause bit-position constants.
- One flat module; no sub-module is warranted.

Test Plan:
- Reset low mid-run with SR=32'h0000_fc01 → all registers read 0 immediately (asynchronous) and req=0 while reset is low.
- mtc0 SR=32'h0000_0401, hw_int=6'b000001 → req=1 same cycle. After the edge: Cause=32'h0000_0400 (ExcCode 0), EXL=1, EPC=vpc.
- exc_code_in=12 (overflow), vpc=32'h0000_3010, bd_in=1 → req=1. After the edge: EPC=32'h0000_300c, Cause[31]=1, ExcCode=12.
- hw_int enabled and exc_code_in=10 in the same cycle → ExcCode=0 (interrupt wins). A following exc_code_in=8 while EXL=1 → req=0, registers unchanged.
- mtc0 EPC=32'h0000_3400 with eret in the same cycle → epc_out=32'h0000_3400 combinationally, EXL cleared after the edge.
- CP0_BADVADDR_EN builds: exc_code_in=4, badvaddr_in=32'h0000_0003 → reg 8 reads 32'h0000_0003. Non-EN builds: reg 8 reads 0.

Source files
------------

// File: rtl/m_cp0_pkg.sv
// Shared definitions for the P7 coprocessor-0: register numbers, exception codes,
// SR/Cause bit positions and the EPC return-address helper.
package m_cp0_pkg;

    localparam logic [4:0] CP0_BADV  = 5'd8;
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IM_HI     = 15;
    localparam int SR_IM_LO     = 10;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // A delay-slot instruction returns to its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/m_cp0.sv
// Coprocessor-0 at the M stage: SR, Cause, EPC, interrupt/exception arbitration.
// Optional BadVAddr register (8) is built when CP0_BADVADDR_EN is defined.
module m_cp0
    import m_cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_0707,
    parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr_in,
`endif
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;
    logic        int_req, exc_req;
    logic [31:0] sr_word, cause_word;
    logic        unused_wdata;

    assign unused_wdata = ^{wdata[31:16], wdata[9:2]};

    // Live hw_int, not the latched IP, so an interrupt is taken in the cycle it rises.
    assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
    assign req     = reset & (int_req | exc_req);

    assign handler_pc = EXC_ENTRY;
    assign epc_out    = (we && addr_w == CP0_EPC && !req) ? wdata : epc_q;

    always_comb begin
        sr_word = 32'd0;
        sr_word[SR_IM_HI:SR_IM_LO] = sr_im_q;
        sr_word[SR_EXL]            = sr_exl_q;
        sr_word[SR_IE]             = sr_ie_q;
        cause_word = 32'd0;
        cause_word[CAUSE_BD]                  = cause_bd_q;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip_q;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_q;
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badv_q, badv_d;

    always_comb begin
        badv_d = badv_q;
        if (req && !int_req && (exc_code_in == EXC_ADEL || exc_code_in == EXC_ADES)) begin
            badv_d = badvaddr_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) badv_q <= 32'd0;
        else        badv_q <= badv_d;
    end
`endif

    always_comb begin
        case (addr_r)
            CP0_SR:    rdata = sr_word;
            CP0_CAUSE: rdata = cause_word;
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
            CP0_BADV:  rdata = badv_q;
`endif
            default:   rdata = 32'd0;
        endcase
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : exc_code_in;
            cause_bd_d  = bd_in;
            epc_d       = epc_of(vpc, bd_in);
        end else begin
            if (we && addr_w == CP0_SR) begin
                sr_im_d  = wdata[SR_IM_HI:SR_IM_LO];
                sr_exl_d = wdata[SR_EXL];
                sr_ie_d  = wdata[SR_IE];
            end
            if (we && addr_w == CP0_EPC) begin
                epc_d = wdata;
            end
            // eret's EXL clear overrides a same-cycle SR write of EXL.
            if (eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_m_cp0.sv
// Scoreboard bench for m_cp0: stimulus pushes expectations, a negedge monitor checks them.
module tb_m_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr_r, addr_w;
    logic [31:0] wdata, rdata, vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] badvaddr_in;
    logic        req;
    logic [31:0] handler_pc, epc_out;

    localparam int K_RDATA = 0;
    localparam int K_REQ   = 1;
    localparam int K_EPC   = 2;
    localparam int K_HPC   = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    m_cp0 dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr_r      (addr_r),
        .addr_w      (addr_w),
        .wdata       (wdata),
        .rdata       (rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
`ifdef CP0_BADVADDR_EN
        .badvaddr_in (badvaddr_in),
`endif
        .req         (req),
        .handler_pc  (handler_pc),
        .epc_out     (epc_out)
    );

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_RDATA: act = rdata;
                K_REQ:   act = {31'd0, req};
                K_EPC:   act = epc_out;
                default: act = handler_pc;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        we = 1'b0; eret = 1'b0; exc_code_in = 5'd0;
    endtask

    task automatic expect_v(input int kind, input logic [31:0] exp, input string tag);
        exp_t e;
        e.kind = kind; e.exp = exp; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr_w = a; wdata = d;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr_r = 5'd12; addr_w = 5'd0; wdata = 32'd0;
        vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
        badvaddr_in = 32'd0;
        #1;
        expect_v(K_RDATA, 32'h0, "reset_sr");
        expect_v(K_REQ, 32'h0, "reset_req");
        expect_v(K_HPC, 32'h0000_4180, "handler_pc");

        tick(); reset = 1'b1;
        mtc0(5'd14, 32'h1234_5678);
        expect_v(K_EPC, 32'h1234_5678, "epc_fwd_plain");
        expect_v(K_REQ, 32'h0, "idle_req");

        tick(); mtc0(5'd12, 32'h0000_fc01); addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0, "no_write_through");

        tick(); addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0000_fc01, "sr_written");
        tick(); addr_r = 5'd14;
        expect_v(K_RDATA, 32'h1234_5678, "epc_written");
        tick(); addr_r = 5'd15;
        expect_v(K_RDATA, 32'h0000_0707, "prid");
        tick(); addr_r = 5'd3;
        expect_v(K_RDATA, 32'h0, "unmapped_reg");

        tick(); reset = 1'b0; hw_int = 6'b111111; addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0, "async_reset_sr");
        expect_v(K_REQ, 32'h0, "async_reset_req");
        expect_v(K_EPC, 32'h0, "async_reset_epc");
        tick(); addr_r = 5'd13;
        expect_v(K_RDATA, 32'h0, "reset_cause");
        expect_v(K_REQ, 32'h0, "reset_hold_req");

        tick(); reset = 1'b1; hw_int = 6'd0; mtc0(5'd12, 32'h0000_0401);
        tick(); hw_int = 6'b000001; vpc = 32'h0000_2000; bd_in = 1'b0;
        expect_v(K_REQ, 32'h1, "int_req");
        tick(); addr_r = 5'd13;
        expect_v(K_RDATA, 32'h0000_0400, "int_cause");
        expect_v(K_REQ, 32'h0, "int_exl_blocks");
        tick(); addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0000_0403, "int_sr_exl");
        tick(); addr_r = 5'd14; hw_int = 6'd0;
        expect_v(K_RDATA, 32'h0000_2000, "int_epc");

        tick(); eret = 1'b1;
        expect_v(K_REQ, 32'h0, "eret_req");
        tick(); exc_code_in = 5'd12; vpc = 32'h0000_3010; bd_in = 1'b1;
        expect_v(K_REQ, 32'h1, "ov_req");
        tick(); addr_r = 5'd13; bd_in = 1'b0;
        expect_v(K_RDATA, 32'h8000_0030, "ov_cause");
        tick(); addr_r = 5'd14;
        expect_v(K_RDATA, 32'h0000_300c, "ov_epc_bd");

        tick(); eret = 1'b1;
        tick(); hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h0000_5000;
        expect_v(K_REQ, 32'h1, "int_vs_ri_req");
        tick(); hw_int = 6'd0; exc_code_in = 5'd8; vpc = 32'h0000_6000; addr_r = 5'd13;
        expect_v(K_RDATA, 32'h0000_0400, "int_wins_cause");
        expect_v(K_REQ, 32'h0, "nested_syscall_req");
        tick(); addr_r = 5'd14;
        expect_v(K_RDATA, 32'h0000_5000, "nested_epc_kept");
        tick(); addr_r = 5'd13;
        expect_v(K_RDATA, 32'h0, "nested_cause_kept");

        tick(); mtc0(5'd14, 32'h0000_3400); eret = 1'b1; addr_r = 5'd12;
        expect_v(K_EPC, 32'h0000_3400, "mtc0_eret_fwd");
        expect_v(K_RDATA, 32'h0000_0403, "pre_eret_sr");
        tick(); addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0000_0401, "eret_cleared");
        expect_v(K_EPC, 32'h0000_3400, "epc_reg_after");

        tick(); mtc0(5'd12, 32'h0000_fc03); eret = 1'b1;
        tick(); addr_r = 5'd12;
        expect_v(K_RDATA, 32'h0000_fc01, "eret_beats_mtc0_exl");

        tick(); mtc0(5'd14, 32'hdead_beef); exc_code_in = 5'd12; vpc = 32'h0000_7000;
        expect_v(K_REQ, 32'h1, "exc_with_mtc0_req");
        expect_v(K_EPC, 32'h0000_3400, "no_fwd_on_req");
        tick(); addr_r = 5'd14;
        expect_v(K_RDATA, 32'h0000_7000, "mtc0_dropped");
        tick(); mtc0(5'd13, 32'hffff_ffff);
        tick(); addr_r = 5'd13;
        expect_v(K_RDATA, 32'h0000_0030, "cause_not_writable");

        tick(); eret = 1'b1;
        tick(); exc_code_in = 5'd4; bd_in = 1'b1; vpc = 32'h0000_0000; badvaddr_in = 32'h0000_0003;
        expect_v(K_REQ, 32'h1, "adel_req");
        tick(); addr_r = 5'd14; bd_in = 1'b0;
        expect_v(K_RDATA, 32'hffff_fffc, "epc_wrap");
        tick(); addr_r = 5'd8;
`ifdef CP0_BADVADDR_EN
        expect_v(K_RDATA, 32'h0000_0003, "badvaddr");
`else
        expect_v(K_RDATA, 32'h0, "badvaddr_absent");
`endif

        tick();
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
